// File: rtl/dense_mxmult_engine_pkg.sv
// Shared types, default parameters and width helpers for the dense matrix-multiply engine.
package dense_mxmult_engine_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    localparam int unsigned LANES_DEFAULT     = 25;
    localparam int unsigned DW_DEFAULT        = 16;
    localparam int unsigned FRAC_DEFAULT      = 8;
    localparam int unsigned K_DEPTH_DEFAULT   = 4;
    localparam int unsigned OUT_DEPTH_DEFAULT = 4;

    // Enough headroom that K_DEPTH worst-case products can never overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k_depth);
        return 2 * dw + $clog2(k_depth);
    endfunction

endpackage

// File: rtl/dense_out_fifo.sv
// Result-row FIFO; head is presented combinationally and reads as zero when empty.
module dense_out_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Gating keeps stale storage from leaking out after reset.
    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dense_mxmult_engine.sv
// Per-lane multiply-accumulate over K_DEPTH beats per row, with shift/saturate/ReLU and an
// output FIFO whose occupancy (plus rows still in the pipeline) throttles input acceptance.
module dense_mxmult_engine
    import dense_mxmult_engine_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DEFAULT,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned FRAC      = FRAC_DEFAULT,
    parameter int unsigned K_DEPTH   = K_DEPTH_DEFAULT,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           num_rows,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_fea,
    input  logic [LANES*DW-1:0]   a_mx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   mult_res,
    output logic                  done
);
    localparam int unsigned ACC_W = acc_width(DW, K_DEPTH);
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned BW    = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(OUT_DEPTH + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_q;
    logic [15:0]         row_q;
    logic [15:0]         num_rows_q;
    logic                relu_q;
    logic [1:0]          pend_q;
    logic                done_q, done_d;
    logic                s1_valid_q, s1_first_q, s1_last_q;
    logic                s2_valid_q;
    logic                accept, last_beat, last_row, pop;
    logic [CW-1:0]       fifo_count;
    logic [LANES*DW-1:0] row_data;

    assign in_ready  = (state_q == StRun) && (32'(fifo_count) + 32'(pend_q) < OUT_DEPTH);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_q == BW'(K_DEPTH - 1));
    assign last_row  = (row_q == num_rows_q - 16'd1);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_rows != '0) begin
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept && last_beat && last_row) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Every row is already committed, so the last pop is the one emptying everything.
                if (pop && fifo_count == CW'(1) && pend_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            row_q      <= '0;
            num_rows_q <= '0;
            relu_q     <= 1'b0;
            pend_q     <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == StIdle && start) begin
                num_rows_q <= num_rows;
                relu_q     <= relu_en;
                beat_q     <= '0;
                row_q      <= '0;
            end
            if (accept) begin
                beat_q <= last_beat ? '0 : beat_q + BW'(1);
                if (last_beat) begin
                    row_q <= last_row ? '0 : row_q + 16'd1;
                end
            end
            s1_valid_q <= accept;
            s1_first_q <= accept && (beat_q == '0);
            s1_last_q  <= accept && last_beat;
            s2_valid_q <= s1_valid_q && s1_last_q;
            pend_q     <= pend_q + 2'(accept && last_beat) - 2'(s2_valid_q);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DW-1:0]    x, w;
        logic signed [PW-1:0]    prod_q;
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] shifted;
        logic [DW-1:0]           res;

        assign x = in_fea[i*DW +: DW];
        assign w = a_mx[i*DW +: DW];

        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                acc_q  <= '0;
            end else begin
                if (accept) begin
                    prod_q <= PW'(x) * PW'(w);
                end
                if (s1_valid_q) begin
                    acc_q <= s1_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
                end
            end
        end

        assign shifted = acc_q >>> FRAC;

        always_comb begin
            res = shifted[DW-1:0];
            if (shifted > SAT_MAX) begin
                res = SAT_MAX[DW-1:0];
            end else if (shifted < SAT_MIN) begin
                res = SAT_MIN[DW-1:0];
            end
            if (relu_q && shifted[ACC_W-1]) begin
                res = '0;
            end
        end

        assign row_data[i*DW +: DW] = res;
    end

    dense_out_fifo #(
        .WIDTH (LANES * DW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid_q),
        .wdata (row_data),
        .pop   (pop),
        .rdata (mult_res),
        .count (fifo_count)
    );

endmodule

// File: doc/dense_mxmult_engine.md
DENSE_MXMULT_ENGINE -- requirements
Module: dense_mxmult_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): LANES, 25, parallel elements per beat; DW, 16, signed fixed-point element width; FRAC, 8, fractional bits; K_DEPTH, 4, beats accumulated per output row; OUT_DEPTH, 4, output FIFO entries.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse that begins a job.
- num_rows  in  16  output rows in the job; latched on start.
- relu_en  in  1  ReLU mode; latched on start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid; also drives need_data.
- in_fea  in  LANES*DW  feature vector; lane i at bits [i*DW +: DW].
- a_mx  in  LANES*DW  weight vector, same packing.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready.
- mult_res  out  LANES*DW  result row.
- done  out  1  one-cycle job-complete pulse.

Function
REQ-003 A beat SHALL transfer only when in_valid=1 and in_ready=1 in the same cycle.
REQ-004 The FSM SHALL have three states: IDLE, RUN and FLUSH.
- IDLE->RUN on start when num_rows!=0.
- RUN->FLUSH when the last beat of the last row is accepted.
- FLUSH->IDLE when the last row is popped.
- start outside IDLE SHALL be ignored.
REQ-005 When start arrives with num_rows=0, the block SHALL pulse done in the next cycle and remain in IDLE.
REQ-006 For each lane, the block SHALL form the full-precision signed product in_fea*a_mx (2*DW bits) and register it one cycle after acceptance.
REQ-007 Each lane SHALL accumulate K_DEPTH products into a signed accumulator of ACC_W = 2*DW + clog2(K_DEPTH) bits, which SHALL never overflow.
- The first beat of a row loads the accumulator; later beats add to it.
REQ-008 Final value SHALL be acc >>> FRAC (arithmetic shift, truncation), saturated to [-2^(DW-1), 2^(DW-1)-1]; if relu_en is latched high, negative results become 0.
REQ-009 A row's result SHALL be written to the FIFO 3 cycles after acceptance of its K_DEPTH-th beat, with no stall in the pipeline.
REQ-010 The pending count pend (0..3) SHALL track rows whose last beat has been accepted but which are not yet written to the FIFO.
REQ-011 in_ready SHALL be high only when all of the following hold (registered or combinational from state, not from in_valid):
- state=RUN;
- beats remain in the job;
- fifo_count+pend < OUT_DEPTH.
REQ-012 The FIFO SHALL preserve row order; a simultaneous push and pop SHALL leave the count unchanged; it SHALL never overflow or underflow.
REQ-013 out_valid SHALL equal fifo_count!=0; mult_res SHALL show the FIFO head and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 done SHALL pulse exactly once per job, in the cycle after the final row is popped.
REQ-015 Beat and row counters SHALL wrap to 0 at K_DEPTH-1 and num_rows-1 respectively.

Reset
REQ-016 When rst=1 the block SHALL return to IDLE, clear all counters, pend, FIFO, accumulators and pipeline valids, and drive in_ready=0, out_valid=0, done=0 and mult_res=0 in the next cycle.
REQ-017 Reset mid-job SHALL discard all in-flight rows, and no stale row SHALL appear after reset.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, the default parameter values and the ACC_W derivation function.
REQ-019 The output FIFO SHALL be one sub-module, dense_out_fifo, parametrised by width and depth; the per-lane MAC SHALL be a generate loop, not a separate module.

Verification (LANES=4, DW=16, FRAC=8, K_DEPTH=2, OUT_DEPTH=4)
REQ-020 num_rows=1, all lanes x=0x0100 and w=0x0100 for 2 beats -> mult_res lanes=0x0200; out_valid 3 cycles after the second beat; done follows the pop.
REQ-021 x=w=0x7FFF -> lanes 0x7FFF; x=0x7FFF, w=0x8000 -> lanes 0x8000.
REQ-022 x=0x0100, w=0xFF00 -> relu_en=0 gives 0xFE00; relu_en=1 gives 0x0000.
REQ-023 num_rows=6 with out_ready=0 -> in_ready drops after 4 rows are accepted; after out_ready=1, six rows emerge in order and done pulses once.
REQ-024 num_rows=0 -> done one cycle after start, and out_valid never asserts.
REQ-025 rst asserted while 2 rows are in flight -> next cycle all outputs 0; a new job then yields only its own results.
